// File: rtl/if_stage_if.sv
// Instruction-memory fetch channel: request/address out, ready/read-data back.
// The fetch stage is the master; the memory is the slave.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, fetches over a
// variable-latency req/ready channel, and handles ID stalls and flush/redirect.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    if_stage_if.master  imem,
    input  logic [31:0] next_pc_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_out_o,
    output logic [31:0] fetch_instr_o,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_instr_o
);

    typedef enum logic [1:0] {FETCH, HOLD, KILL} state_t;

    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_npc_q, hold_npc_d;
    logic [31:0] pend_q, pend_d;

    // PCs are word aligned; the low two bits of incoming targets are dropped.
    logic [31:0] npc_al, rpc_al;
    logic        unused_low_bits;
    assign npc_al          = {next_pc_i[31:2], 2'b00};
    assign rpc_al          = {redirect_pc_i[31:2], 2'b00};
    assign unused_low_bits = ^{next_pc_i[1:0], redirect_pc_i[1:0]};

    // Request is a pure function of state; it is also held low throughout reset.
    assign imem.imem_req  = rst_n && (state_q != HOLD);
    assign imem.imem_addr = pc_q;
    assign pc_out_o       = pc_q;
    assign fetch_instr_o  = imem.imem_rdata;
    assign ifid_valid_o   = ifid_valid_q;
    assign ifid_pc_o      = ifid_pc_q;
    assign ifid_instr_o   = ifid_instr_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        hold_npc_d   = hold_npc_q;
        pend_d       = pend_q;
        case (state_q)
            FETCH: begin
                if (flush_i) begin
                    ifid_valid_d = 1'b0;
                    if (imem.imem_ready) begin
                        pc_d = rpc_al;
                    end else begin
                        pend_d  = rpc_al;
                        state_d = KILL;
                    end
                end else if (imem.imem_ready) begin
                    if (!stall_i) begin
                        ifid_valid_d = 1'b1;
                        ifid_pc_d    = pc_q;
                        ifid_instr_d = imem.imem_rdata;
                        pc_d         = npc_al;
                    end else begin
                        // ID is busy: park the returned word until it drains.
                        hold_pc_d    = pc_q;
                        hold_instr_d = imem.imem_rdata;
                        hold_npc_d   = npc_al;
                        state_d      = HOLD;
                    end
                end else if (!stall_i) begin
                    ifid_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (flush_i) begin
                    ifid_valid_d = 1'b0;
                    pc_d         = rpc_al;
                    state_d      = FETCH;
                end else if (!stall_i) begin
                    ifid_valid_d = 1'b1;
                    ifid_pc_d    = hold_pc_q;
                    ifid_instr_d = hold_instr_q;
                    pc_d         = hold_npc_q;
                    state_d      = FETCH;
                end
            end
            KILL: begin
                // Let the outstanding request finish, then jump to the newest target.
                if (flush_i) begin
                    pend_d       = rpc_al;
                    ifid_valid_d = 1'b0;
                end
                if (imem.imem_ready) begin
                    pc_d    = flush_i ? rpc_al : pend_q;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC_AL;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= '0;
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
            hold_npc_q   <= '0;
            pend_q       <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            hold_npc_q   <= hold_npc_d;
            pend_q       <= pend_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: zero-wait fetch, wait states, stall/hold,
// flush/redirect in each state, and asynchronous reset during a kill.
module tb_if_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] next_pc;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] pc_out;
    logic [31:0] fetch_instr;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic [31:0] np_junk;
    logic [31:0] exp_pc;
    int          n_chk  = 0;
    int          n_pass = 0;
    ent_t        sb[$];

    if_stage_if mem ();

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem         (mem),
        .next_pc_i    (next_pc),
        .stall_i      (stall),
        .flush_i      (flush),
        .redirect_pc_i(redirect_pc),
        .pc_out_o     (pc_out),
        .fetch_instr_o(fetch_instr),
        .ifid_valid_o (ifid_valid),
        .ifid_pc_o    (ifid_pc),
        .ifid_instr_o (ifid_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hA5C3_0000 ^ {a[15:0], a[31:16]} ^ a;
    endfunction

    // Instruction memory contents and the next-PC logic (sequential +4).
    always_comb mem.imem_rdata = word_at(mem.imem_addr);
    assign next_pc = pc_out + 32'd4 + np_junk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick(input logic rdy, input logic st, input logic fl, input logic [31:0] rpc);
        mem.imem_ready = rdy;
        stall          = st;
        flush          = fl;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
        mem.imem_ready = 1'b0;
        stall          = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        ent_t e;
        if (sb.size() == 0) begin
            n_chk++;
            assert (0) else $error("FAIL %s: observed ifid_pc %h expected scoreboard entry", tag, ifid_pc);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, {31'd0, ifid_valid}, 32'd1);
            chk({tag, "_pc"}, ifid_pc, e.pc);
            chk({tag, "_instr"}, ifid_instr, e.instr);
        end
    endtask

    // One zero-wait accept at exp_pc with ID free.
    task automatic fetch_ok(input string tag);
        chk({tag, "_addr"}, mem.imem_addr, exp_pc);
        sb.push_back('{pc: exp_pc, instr: word_at(exp_pc)});
        tick(1'b1, 1'b0, 1'b0, 32'd0);
        exp_pc = exp_pc + 32'd4;
        pop_check(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        mem.imem_ready = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        redirect_pc = '0;
        np_junk = '0;
        exp_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, mem.imem_req}, 32'd0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("rst_ifid_pc", ifid_pc, 32'h0);
        chk("rst_ifid_instr", ifid_instr, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_req", {31'd0, mem.imem_req}, 32'd1);
        chk("fetch_instr", fetch_instr, word_at(32'h0));

        fetch_ok("seq0");
        fetch_ok("seq4");
        fetch_ok("seq8");
        fetch_ok("seqC");

        // Two wait states at 0x10.
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0, 1'b0, 32'd0);
            chk("ws_addr", mem.imem_addr, 32'h10);
            chk("ws_req", {31'd0, mem.imem_req}, 32'd1);
            chk("ws_bubble", {31'd0, ifid_valid}, 32'd0);
        end
        fetch_ok("ws10");
        fetch_ok("seq14");
        fetch_ok("seq18");
        fetch_ok("seq1C");

        // Stall three cycles while 0x20 returns.
        sb.push_back('{pc: 32'h20, instr: word_at(32'h20)});
        tick(1'b1, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("hold_req", {31'd0, mem.imem_req}, 32'd0);
            chk("hold_ifid_pc", ifid_pc, 32'h1C);
            chk("hold_addr", mem.imem_addr, 32'h20);
            if (i < 2) tick(1'b0, 1'b1, 1'b0, 32'd0);
        end
        tick(1'b0, 1'b0, 1'b0, 32'd0);
        pop_check("hold_release");
        exp_pc = 32'h24;
        fetch_ok("seq24");
        fetch_ok("seq28");
        fetch_ok("seq2C");

        // Flush while 0x30 outstanding; ready arrives two cycles later.
        tick(1'b0, 1'b0, 1'b1, 32'h400);
        chk("kill_valid", {31'd0, ifid_valid}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            chk("kill_addr", mem.imem_addr, 32'h30);
            chk("kill_req", {31'd0, mem.imem_req}, 32'd1);
            tick(1'b0, 1'b0, 1'b0, 32'd0);
        end
        tick(1'b1, 1'b0, 1'b0, 32'd0);
        chk("kill_valid_done", {31'd0, ifid_valid}, 32'd0);
        exp_pc = 32'h400;
        fetch_ok("redir400");

        // Flush and stall together in HOLD.
        tick(1'b1, 1'b1, 1'b0, 32'd0);
        chk("hf_req", {31'd0, mem.imem_req}, 32'd0);
        tick(1'b0, 1'b1, 1'b1, 32'h80);
        chk("hf_valid", {31'd0, ifid_valid}, 32'd0);
        chk("hf_req2", {31'd0, mem.imem_req}, 32'd1);
        exp_pc = 32'h80;
        fetch_ok("redir80");

        // Flush with ready in FETCH; misaligned target and next_pc are aligned.
        tick(1'b1, 1'b0, 1'b1, 32'h207);
        chk("fr_valid", {31'd0, ifid_valid}, 32'd0);
        exp_pc = 32'h204;
        np_junk = 32'd3;
        fetch_ok("npc_align");
        np_junk = 32'd0;

        // Second flush in KILL overrides the pending target.
        tick(1'b0, 1'b0, 1'b1, 32'h500);
        tick(1'b0, 1'b0, 1'b1, 32'h600);
        chk("kk_addr", mem.imem_addr, 32'h208);
        tick(1'b1, 1'b0, 1'b0, 32'd0);
        chk("kk_target", mem.imem_addr, 32'h600);
        exp_pc = 32'h600;
        fetch_ok("redir600");

        // Asynchronous reset while in KILL.
        tick(1'b0, 1'b0, 1'b1, 32'h700);
        rst_n = 1'b0;
        #1;
        chk("ar_pc", pc_out, 32'h0);
        chk("ar_req", {31'd0, mem.imem_req}, 32'd0);
        chk("ar_valid", {31'd0, ifid_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        exp_pc = 32'h0;
        chk("ar_rel_req", {31'd0, mem.imem_req}, 32'd1);
        fetch_ok("ar_restart");
        chk("ar_no_stale", mem.imem_addr, 32'h4);
        chk("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
